// File: rtl/fifo_stream_framer.sv
// fifo_stream_framer: pops words from a synchronous FIFO, buffers them in a
// 2-entry queue to hide the FIFO read latency, and presents them as a
// valid/ready stream with every FRAME_LEN-th word tagged m_last.
module fifo_stream_framer #(
  parameter int FIFO_WIDTH = 16,
  parameter int FRAME_LEN  = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_W-1:0]      frames_done,
  output logic                  busy
);

  localparam int IDX_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t                  state;
  logic [IDX_W-1:0]        issue_idx;
  logic                    inflight;
  logic                    inflight_last;
  logic [1:0]              occ;
  logic [FIFO_WIDTH-1:0]   head_data;
  logic                    head_last;
  logic [FIFO_WIDTH-1:0]   tail_data;
  logic                    tail_last;

  logic                    pop;
  logic [2:0]              fill;
  logic [2:0]              limit;
  logic                    issuing_state;

  assign m_valid = (occ != 2'd0);
  assign m_data  = head_data;
  assign m_last  = head_last;
  assign busy    = (state != IDLE) || (occ != 2'd0) || inflight;

  // Issue a read only when a buffer slot will be free for its data; a word
  // popped this cycle frees a slot, hence the intentional m_ready path.
  // A new frame is never started once en has dropped.
  always_comb begin
    pop           = m_valid && m_ready;
    fill          = {1'b0, occ} + {2'b00, inflight};
    limit         = 3'd2 + {2'b00, pop};
    issuing_state = (state == RUN) || (state == FINISH);
    fifo_rd_en    = !fifo_empty && (fill < limit) && issuing_state &&
                    (en || (issue_idx != '0));
  end

  // FSM, read-issue bookkeeping, output buffer and frame counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      issue_idx     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      occ           <= 2'd0;
      head_data     <= '0;
      head_last     <= 1'b0;
      tail_data     <= '0;
      tail_last     <= 1'b0;
      frames_done   <= '0;
    end else begin
      inflight      <= fifo_rd_en;
      inflight_last <= fifo_rd_en && (issue_idx == LAST_IDX);
      if (fifo_rd_en) begin
        issue_idx <= (issue_idx == LAST_IDX) ? '0 : issue_idx + IDX_W'(1);
      end

      case ({inflight, pop})
        2'b01: begin
          head_data <= tail_data;
          head_last <= tail_last;
          occ       <= occ - 2'd1;
        end
        2'b10: begin
          if (occ == 2'd0) begin
            head_data <= fifo_dout;
            head_last <= inflight_last;
          end else begin
            tail_data <= fifo_dout;
            tail_last <= inflight_last;
          end
          occ <= occ + 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            head_data <= fifo_dout;
            head_last <= inflight_last;
          end else begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_data <= fifo_dout;
            tail_last <= inflight_last;
          end
        end
        default: begin
        end
      endcase

      if (pop && head_last) begin
        frames_done <= frames_done + CNT_W'(1);
      end

      case (state)
        IDLE: begin
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) state <= (issue_idx == '0) ? IDLE : FINISH;
        end
        FINISH: begin
          if (en) state <= RUN;
          else if (issue_idx == '0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(inflight && !pop && (occ == 2'd2)));

endmodule

// File: tb/tb_fifo_stream_framer.sv
// tb_fifo_stream_framer: drives the framer from a queue-based FIFO model and
// compares the output stream against the word order read from that FIFO,
// with frame position and frame count derived from plain word counting.
module tb_fifo_stream_framer;

  localparam int W  = 16;
  localparam int FL = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          fifo_empty;
  logic [W-1:0]  fifo_dout;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic          m_last;
  logic [CW-1:0] frames_done;
  logic          busy;

  int compared   = 0;
  int mismatched = 0;

  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  int           pos      = 0;
  int           frames   = 0;
  int           reads    = 0;
  logic [W-1:0] next_val = 16'h0001;

  // Free-running clock.
  always #5 clk = ~clk;

  fifo_stream_framer #(
    .FIFO_WIDTH(W),
    .FRAME_LEN (FL),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .frames_done(frames_done),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic r, input int npush);
    en      = e;
    m_ready = r;
    for (int i = 0; i < npush; i++) begin
      if (fq.size() < 8) begin
        fq.push_back(next_val);
        next_val++;
      end
    end
    fifo_empty = (fq.size() == 0);
    #1;
  endtask

  task automatic checkOutput();
    logic         rd;
    logic         pp;
    logic [W-1:0] w;
    rd = fifo_rd_en;
    pp = m_valid && m_ready;
    check("rd_while_empty", 32'(rd && fifo_empty), 32'd0);
    check("rd_after_en_drop", 32'(rd && !en && ((reads % FL) == 0)), 32'd0);
    check("outstanding_le2", 32'((exp_q.size() + int'(rd) - int'(pp)) <= 2), 32'd1);
    check("valid_without_data", 32'(m_valid && (exp_q.size() == 0)), 32'd0);
    check("frames_done", 32'(frames_done), 32'(frames % 256));
    if (pp && (exp_q.size() > 0)) begin
      check("m_data", 32'(m_data), 32'(exp_q[0]));
      check("m_last", 32'(m_last), 32'(pos == FL - 1));
    end
    @(posedge clk);
    #1;
    if (pp && (exp_q.size() > 0)) begin
      w = exp_q.pop_front();
      if (pos == FL - 1) frames++;
      pos = (pos + 1) % FL;
    end
    if (rd && (fq.size() > 0)) begin
      w = fq.pop_front();
      exp_q.push_back(w);
      fifo_dout = w;
      reads++;
    end
    fifo_empty = (fq.size() == 0);
    @(negedge clk);
  endtask

  task automatic cycle(input logic e, input logic r, input int npush);
    applyStimulus(e, r, npush);
    checkOutput();
  endtask

  // Directed scenarios followed by a randomized run and counter wrap.
  initial begin
    int lat;
    int base;
    int fbase;
    int n;

    rst_n      = 1'b0;
    en         = 1'b0;
    m_ready    = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    #2;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_frames", 32'(frames_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] full throughput from preloaded FIFO");
    cycle(1'b0, 1'b1, 8);
    lat = 0;
    do begin
      cycle(1'b1, 1'b1, 0);
      lat++;
    end while (!m_valid && lat < 20);
    check("startup_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 8; i++) begin
      check("t1_valid", 32'(m_valid), 32'd1);
      check("t1_data", 32'(m_data), 32'(i + 1));
      check("t1_last", 32'(m_last), 32'((i == 3) || (i == 7)));
      cycle(1'b1, 1'b1, 0);
    end
    check("t1_frames", 32'(frames_done), 32'd2);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 0);
    check("t1_idle_busy", 32'(busy), 32'd0);

    $display("[TB] stalled sink");
    base = reads;
    cycle(1'b1, 1'b0, 8);
    for (int i = 0; i < 9; i++) begin
      if (m_valid) check("t2_hold_data", 32'(m_data), 32'h0009);
      cycle(1'b1, 1'b0, 0);
    end
    check("t2_reads", 32'(reads - base), 32'd2);
    check("t2_valid", 32'(m_valid), 32'd1);
    check("t2_head", 32'(m_data), 32'h0009);
    for (int i = 0; i < 8; i++) begin
      check("t2_valid_drain", 32'(m_valid), 32'd1);
      check("t2_data_drain", 32'(m_data), 32'(9 + i));
      cycle(1'b1, 1'b1, 0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 0);

    $display("[TB] enable dropped mid-frame");
    base  = reads;
    fbase = frames;
    cycle(1'b1, 1'b1, 8);
    n = 0;
    while ((reads - base) < 2 && n < 20) begin
      cycle(1'b1, 1'b1, 0);
      n++;
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 0);
    check("t3_reads", 32'(reads - base), 32'd4);
    check("t3_left_in_fifo", 32'(fq.size()), 32'd4);
    check("t3_frames", 32'(frames_done), 32'(fbase + 1));
    check("t3_idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 0);

    $display("[TB] FIFO runs empty mid-frame");
    fbase = frames;
    cycle(1'b1, 1'b1, 2);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 0);
    check("t4_stalled_frames", 32'(frames_done), 32'(fbase));
    check("t4_stalled_busy", 32'(busy), 32'd1);
    check("t4_stalled_valid", 32'(m_valid), 32'd0);
    cycle(1'b1, 1'b1, 2);
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 0);
    check("t4_frames", 32'(frames_done), 32'(fbase + 1));
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 0);

    $display("[TB] asynchronous reset with full buffer");
    cycle(1'b1, 1'b0, 8);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 0);
    check("t5_pre_occ", 32'(m_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_m_valid", 32'(m_valid), 32'd0);
    check("t5_m_data", 32'(m_data), 32'd0);
    check("t5_m_last", 32'(m_last), 32'd0);
    check("t5_rd_en", 32'(fifo_rd_en), 32'd0);
    check("t5_frames", 32'(frames_done), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    exp_q.delete();
    pos    = 0;
    frames = 0;
    reads  = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b1, 1'b1, 2);
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b1, 0);
    check("t5_frames_after", 32'(frames_done), 32'd2);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      cycle(1'b1, ($urandom_range(0, 9) < 8), (($urandom_range(0, 9) < 9) ? 1 : 0));
    end

    $display("[TB] frame counter wrap");
    n = 0;
    while ((frames % 256) != 255 && n < 3000) begin
      cycle(1'b1, 1'b1, 1);
      n++;
    end
    check("wrap_pre", 32'(frames_done), 32'h00FF);
    n = 0;
    while ((frames % 256) != 0 && n < 50) begin
      cycle(1'b1, 1'b1, 1);
      n++;
    end
    check("wrap_post", 32'(frames_done), 32'h0000);

    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 0);
    check("final_busy", 32'(busy), 32'd0);
    check("final_valid", 32'(m_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
